// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU definitions: word width, reset vector, bubble encoding and the
// opcodes the ID stage uses for branch/jump target computation.
package cpu_defs;
    localparam int          WORD_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] BUBBLE   = NOP;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_J     = 6'b000010;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] inst;
        logic              valid;
    } ifid_t;

    // Fetch addresses are always word aligned.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: ROM port, hazard/redirect controls and the IF/ID register view.
interface if_fetch_unit_if;
    import cpu_defs::*;

    logic [WORD_W-1:0] InstAddr;
    logic [WORD_W-1:0] Inst;
    logic              Stall;
    logic              BranchTaken;
    logic [WORD_W-1:0] BranchTarget;
    logic              Jump;
    logic [WORD_W-1:0] JumpTarget;
    logic [WORD_W-1:0] IfIdPC;
    logic [WORD_W-1:0] IfIdPC4;
    logic [WORD_W-1:0] IfIdInst;
    logic              IfIdValid;

    modport master (
        output InstAddr, IfIdPC, IfIdPC4, IfIdInst, IfIdValid,
        input  Inst, Stall, BranchTaken, BranchTarget, Jump, JumpTarget
    );

    modport slave (
        input  InstAddr, IfIdPC, IfIdPC4, IfIdInst, IfIdValid,
        output Inst, Stall, BranchTaken, BranchTarget, Jump, JumpTarget
    );
endinterface

// File: rtl/if_fetch_unit_pc_next_sel.sv
// Combinational next-PC priority mux: branch, then jump, then stall, then PC+4.
module pc_next_sel
    import cpu_defs::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [WORD_W-1:0] next_pc,
    output logic              redirect
);
    // A taken branch belongs to the older instruction, so a concurrent jump
    // is wrong-path; any redirect also makes the stalled fetch wrong-path.
    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        if (branch_taken) begin
            next_pc  = align_word(branch_target);
            redirect = 1'b1;
        end else if (jump) begin
            next_pc  = align_word(jump_target);
            redirect = 1'b1;
        end else if (stall) begin
            next_pc = pc;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, ROM addressing and the IF/ID register.
// Optional IF_PERF_CNT_EN adds FetchCount/FlushCount performance counters.
module if_fetch_unit
    import cpu_defs::*;
(
    input  logic             Clk,
    input  logic             Reset,
    if_fetch_unit_if.master  bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      FetchCount,
    output logic [31:0]      FlushCount
`endif
);
    logic [WORD_W-1:0] pc_reg;
    logic [WORD_W-1:0] pc_next;
    logic [WORD_W-1:0] pc_plus4;
    logic              redirect;
    ifid_t             ifid_reg;

    assign pc_plus4 = pc_reg + 32'd4;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_reg),
        .stall         (bus.Stall),
        .branch_taken  (bus.BranchTaken),
        .branch_target (bus.BranchTarget),
        .jump          (bus.Jump),
        .jump_target   (bus.JumpTarget),
        .next_pc       (pc_next),
        .redirect      (redirect)
    );

    // A redirect replaces the in-flight fetch with a bubble so the wrong-path
    // word never reaches decode; a stall freezes IF/ID as-is.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg   <= RESET_PC;
            ifid_reg <= '{pc: '0, pc4: '0, inst: BUBBLE, valid: 1'b0};
        end else begin
            pc_reg <= pc_next;
            if (redirect) begin
                ifid_reg <= '{pc: pc_reg, pc4: pc_plus4, inst: BUBBLE, valid: 1'b0};
            end else if (!bus.Stall) begin
                ifid_reg <= '{pc: pc_reg, pc4: pc_plus4, inst: bus.Inst, valid: 1'b1};
            end
        end
    end

    assign bus.InstAddr  = pc_reg;
    assign bus.IfIdPC    = ifid_reg.pc;
    assign bus.IfIdPC4   = ifid_reg.pc4;
    assign bus.IfIdInst  = ifid_reg.inst;
    assign bus.IfIdValid = ifid_reg.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (!redirect && !bus.Stall) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end
            if (redirect) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign FetchCount = fetch_count_reg;
    assign FlushCount = flush_count_reg;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a driver pushes hand-computed IF/ID and PC
// expectations into a queue, and a monitor pops and compares after each edge.
module tb_if_fetch_unit;
    logic Clk;
    logic Reset;

    if_fetch_unit_if bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    if_fetch_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .FetchCount (FetchCount),
        .FlushCount (FlushCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] rom [0:255];
    assign bus.Inst = rom[bus.InstAddr[9:2]];

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] inst;
        logic        valid;
    } exp_t;

    exp_t exp_q [$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   exp_fetch  = 0;
    int   exp_flush  = 0;

    function automatic logic [31:0] rw(input logic [31:0] addr);
        return rom[addr[9:2]];
    endfunction

    // Drive one cycle of inputs before the edge and queue the state expected after it.
    task automatic step(input string name, input logic rst, input logic stall,
                        input logic br, input logic [31:0] bt,
                        input logic jmp, input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                        input logic [31:0] e_inst, input logic e_valid);
        exp_t e;
        @(negedge Clk);
        Reset            = rst;
        bus.Stall        = stall;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = jmp;
        bus.JumpTarget   = jt;
        e.name  = name;
        e.pc    = e_pc;
        e.ifpc  = e_ifpc;
        e.ifpc4 = rst ? 32'h0 : e_ifpc + 32'd4;
        e.inst  = e_inst;
        e.valid = e_valid;
        exp_q.push_back(e);
        if (rst) begin
            exp_fetch = 0;
            exp_flush = 0;
        end else if (br || jmp) begin
            exp_flush++;
        end else if (!stall) begin
            exp_fetch++;
        end
    endtask

    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.InstAddr !== e.pc || bus.IfIdPC !== e.ifpc || bus.IfIdPC4 !== e.ifpc4 ||
                bus.IfIdInst !== e.inst || bus.IfIdValid !== e.valid) begin
                miscompares++;
                $display("FAIL %s: got pc=%h ifpc=%h ifpc4=%h inst=%h v=%b, want pc=%h ifpc=%h ifpc4=%h inst=%h v=%b",
                         e.name, bus.InstAddr, bus.IfIdPC, bus.IfIdPC4, bus.IfIdInst, bus.IfIdValid,
                         e.pc, e.ifpc, e.ifpc4, e.inst, e.valid);
            end else begin
                $display("ok   %s: pc=%h ifpc=%h inst=%h v=%b", e.name, bus.InstAddr,
                         bus.IfIdPC, bus.IfIdInst, bus.IfIdValid);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[0]  = 32'h3401_0001;
        rom[10] = 32'h3409_0009;
        rom[14] = 32'h340C_000C;

        Reset = 1'b1;
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
        bus.Jump = 1'b0; bus.JumpTarget = '0;

        //    name            rst stall br  bt            jmp jt            pc            ifpc          inst          v
        step("reset_a",       1, 1, 0, 32'h0,         1, 32'h80,        32'h0,        32'h0,        32'h0,        0);
        step("reset_b",       1, 1, 0, 32'h0,         1, 32'h80,        32'h0,        32'h0,        32'h0,        0);
        step("first_fetch",   0, 0, 0, 32'h0,         0, 32'h0,         32'h4,        32'h0,        32'h3401_0001, 1);
        step("seq_04",        0, 0, 0, 32'h0,         0, 32'h0,         32'h8,        32'h4,        rw(32'h4),    1);
        step("seq_08",        0, 0, 0, 32'h0,         0, 32'h0,         32'hC,        32'h8,        rw(32'h8),    1);
        step("stall_1",       0, 1, 0, 32'h0,         0, 32'h0,         32'hC,        32'h8,        rw(32'h8),    1);
        step("stall_2",       0, 1, 0, 32'h0,         0, 32'h0,         32'hC,        32'h8,        rw(32'h8),    1);
        step("resume_0c",     0, 0, 0, 32'h0,         0, 32'h0,         32'h10,       32'hC,        rw(32'hC),    1);
        step("seq_10",        0, 0, 0, 32'h0,         0, 32'h0,         32'h14,       32'h10,       rw(32'h10),   1);
        step("seq_14",        0, 0, 0, 32'h0,         0, 32'h0,         32'h18,       32'h14,       rw(32'h14),   1);
        step("seq_18",        0, 0, 0, 32'h0,         0, 32'h0,         32'h1C,       32'h18,       rw(32'h18),   1);
        step("seq_1c",        0, 0, 0, 32'h0,         0, 32'h0,         32'h20,       32'h1C,       rw(32'h1C),   1);
        step("seq_20",        0, 0, 0, 32'h0,         0, 32'h0,         32'h24,       32'h20,       rw(32'h20),   1);
        step("branch_bubble", 0, 0, 1, 32'h28,        0, 32'h0,         32'h28,       32'h24,       32'h0,        0);
        step("branch_target", 0, 0, 0, 32'h0,         0, 32'h0,         32'h2C,       32'h28,       32'h3409_0009, 1);
        step("seq_2c",        0, 0, 0, 32'h0,         0, 32'h0,         32'h30,       32'h2C,       rw(32'h2C),   1);
        step("jump_stall",    0, 1, 0, 32'h0,         1, 32'h38,        32'h38,       32'h30,       32'h0,        0);
        step("jump_target",   0, 0, 0, 32'h0,         0, 32'h0,         32'h3C,       32'h38,       32'h340C_000C, 1);
        step("br_and_jump",   0, 0, 1, 32'h40,        1, 32'h80,        32'h40,       32'h3C,       32'h0,        0);
        step("br_j_target",   0, 0, 0, 32'h0,         0, 32'h0,         32'h44,       32'h40,       rw(32'h40),   1);
        step("unaligned_tgt", 0, 0, 1, 32'h4B,        0, 32'h0,         32'h48,       32'h44,       32'h0,        0);
        step("unaligned_fet", 0, 0, 0, 32'h0,         0, 32'h0,         32'h4C,       32'h48,       rw(32'h48),   1);
        step("jump_top",      0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h4C,      32'h0,        0);
        step("pc_wrap",       0, 0, 0, 32'h0,         0, 32'h0,         32'h0,        32'hFFFF_FFFC, rw(32'hFFFF_FFFC), 1);
        step("seq_after_wrap",0, 0, 0, 32'h0,         0, 32'h0,         32'h4,        32'h0,        32'h3401_0001, 1);
        step("reset_mid_br",  1, 0, 1, 32'h40,        0, 32'h0,         32'h0,        32'h0,        32'h0,        0);
        step("refetch_0",     0, 0, 0, 32'h0,         0, 32'h0,         32'h4,        32'h0,        32'h3401_0001, 1);
        step("reset_mid_stl", 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        32'h0,        0);
        step("refetch_0b",    0, 0, 0, 32'h0,         0, 32'h0,         32'h4,        32'h0,        32'h3401_0001, 1);
        step("seq_04b",       0, 0, 0, 32'h0,         0, 32'h0,         32'h8,        32'h4,        rw(32'h4),    1);

        @(negedge Clk);
        bus.Stall = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

`ifdef IF_PERF_CNT_EN
        vectors++;
        if (FetchCount !== 32'(exp_fetch) || FlushCount !== 32'(exp_flush)) begin
            miscompares++;
            $display("FAIL perf_counts: got fetch=%0d flush=%0d, want fetch=%0d flush=%0d",
                     FetchCount, FlushCount, exp_fetch, exp_flush);
        end else begin
            $display("ok   perf_counts: fetch=%0d flush=%0d", FetchCount, FlushCount);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage pipelined CPU. Owns the program counter, drives the instruction ROM address and registers the returned word into the IF/ID pipeline register. Applies stall requests from hazard detection and redirects from branch/jump resolution. Inserts bubbles for control-hazard flushes so wrong-path instructions never reach decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BUBBLE, 32'h0000_0000, instruction word injected on flush (sll $0,$0,0)
- Clk  input  1  pipeline clock; all state updates on rising edge
- Reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- InstAddr  output  32  byte address to instruction ROM; equals PC combinationally
- Inst  input  32  instruction word from ROM (combinational read of word InstAddr[9:2])
- Stall  input  1  hold PC and IF/ID (load-use hazard)
- BranchTaken  input  1  branch resolved taken this cycle
- BranchTarget  input  32  byte address of branch target
- Jump  input  1  j decoded in ID this cycle
- JumpTarget  input  32  byte address of jump target
- IfIdPC  output  32  PC of instruction held in IF/ID
- IfIdPC4  output  32  IfIdPC + 4
- IfIdInst  output  32  instruction held in IF/ID
- IfIdValid  output  1  IF/ID holds a real (non-bubble) instruction

## Operation
- PC register, reset to RESET_PC. InstAddr = PC.
- Next-PC priority, highest first: BranchTaken -> BranchTarget; Jump -> JumpTarget; Stall -> PC; else PC+4.
- Branch outranks Jump: branch is from the older instruction, the jump is on its wrong path.
- Redirect (BranchTaken or Jump) overrides Stall: the stalled instruction is wrong-path.
- IF/ID update: redirect -> load {PC, PC+4, BUBBLE, Valid=0}; else Stall -> hold all fields; else load {PC, PC+4, Inst, Valid=1}.
- Flushing ID/EX on BranchTaken is the hazard unit's job, not this block's.
- PC arithmetic modulo 2^32; PC+4 wraps 32'hFFFF_FFFC -> 0. Targets are taken as given; bits [1:0] forced to 0 on load.

## Timing
- Reset asserted: next edge PC=RESET_PC, IfIdPC=0, IfIdPC4=0, IfIdInst=BUBBLE, IfIdValid=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- Cycle after reset release: IF/ID receives instruction at RESET_PC.
- Fetch latency: instruction at PC in cycle t appears on IfIdInst in cycle t+1.
- Redirect in cycle t: bubble in IF/ID at t+1, target instruction in IF/ID at t+2.
- Stall held N cycles: PC and IF/ID frozen N cycles; fetch resumes on first cycle Stall=0.
- Redirect concurrent with Stall: redirect wins; no freeze.
- BranchTaken and Jump concurrent: BranchTarget loaded, one bubble.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs FetchCount[31:0] (increments each edge IF/ID loads Valid=1) and FlushCount[31:0] (increments each redirect edge); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package cpu_defs: RESET_PC default, BUBBLE/NOP encoding, word width 32, opcode constants for beq (6'b000100) and j (6'b000010) used by ID-stage target computation.
- One sub-module: pc_next_sel, combinational next-PC priority mux; PC register and IF/ID register live in if_fetch_unit.

## Test plan
- Reset with Stall=1, Jump=1 -> PC=0, IfIdValid=0, IfIdInst=0; release -> IfIdInst=ROM[0] (0x34010001), IfIdPC=0 next cycle.
- Straight-line fetch of words 0-6 -> IfIdPC steps 0x00..0x18 by 4, IfIdPC4=IfIdPC+4, Valid=1 each cycle.
- Stall=1 for 2 cycles with PC=0x0C -> InstAddr=0x0C, IfIdPC=0x08 held both cycles; fetch of 0x0C resumes after.
- BranchTaken=1, BranchTarget=0x28 while PC=0x24 -> next cycle bubble (Valid=0), then IfIdPC=0x28, IfIdInst=0x34090009.
- Jump=1, JumpTarget=0x38 while PC=0x30, Stall=1 same cycle -> bubble, then IfIdPC=0x38, IfIdInst=0x340C000C; words 0x30/0x34 never Valid.
- BranchTaken=1 (target 0x40) and Jump=1 (target 0x80) same cycle -> PC=0x40; with IF_PERF_CNT_EN, FlushCount+=1 only.
